// File: rtl/stream_rr_arb_reg.sv
// stream_rr_arb_reg: round-robin arbiter feeding one registered stream stage.
// Optional macro STREAM_RR_ARB_REG_GRANT_CNT_EN adds per-input grant counters.
//
// Ports:
//   clk_i, rst_i (sync, active-high), clr_i (sync clear, same effect as reset)
//   valid_i/ready_o/data_i : NumInp requester streams
//   valid_o/ready_i/data_o : registered output stream
//   idx_o                  : index of the requester whose beat is in data_o
//   grant_cnt_o            : saturating grant counters (macro defined only)
module stream_rr_arb_reg #(
  parameter int unsigned NumInp   = 4,
  parameter type         T        = logic,
  parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [NumInp-1:0]   valid_i,
  output logic [NumInp-1:0]   ready_o,
  input  T     [NumInp-1:0]   data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [IdxWidth-1:0] idx_o
`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
  ,
  output logic [NumInp-1:0][CntWidth-1:0] grant_cnt_o
`endif
);

  localparam int unsigned SW = IdxWidth + 1;
  localparam logic [SW-1:0] NumS = SW'(NumInp);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumInp - 1);

  logic                valid_q, valid_d;
  T                    data_q, data_d;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic [IdxWidth-1:0] rr_q, rr_d;

  logic                out_ready;
  logic                any_valid;
  logic                xfer;
  logic                clear;
  logic [IdxWidth-1:0] win;
  logic [SW-1:0]       cand;

  assign clear     = clr_i | rst_i;
  assign out_ready = ready_i | ~valid_q;
  assign any_valid = |valid_i;
  // A clear cycle accepts nothing, so no handshake is offered.
  assign xfer      = out_ready & any_valid & ~clear;

  // Scan offsets from the far end down so the closest valid
  // requester to rr_q is the last (winning) assignment.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int i = NumInp - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + SW'(i);
      if (cand >= NumS) begin
        cand = cand - NumS;
      end
      if (valid_i[cand[IdxWidth-1:0]]) begin
        win = cand[IdxWidth-1:0];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < NumInp; k++) begin
      ready_o[k] = xfer & (win == IdxWidth'(k));
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
      idx_d   = '0;
      rr_d    = '0;
    end else if (xfer) begin
      valid_d = 1'b1;
      data_d  = data_i[win];
      idx_d   = win;
      rr_d    = (win == LastIdx) ?
                '0 : win + IdxWidth'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
  logic [NumInp-1:0][CntWidth-1:0] cnt_q, cnt_d;

  // Counters stop at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (xfer && (cnt_q[win] != '1)) begin
      cnt_d[win] = cnt_q[win] + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  logic [CntWidth-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_rr_arb_reg.sv
// tb_stream_rr_arb_reg: checks stream_rr_arb_reg (NumInp=4 and NumInp=3)
// against a cycle-level behavioural model.
module tb_stream_rr_arb_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;

  logic [3:0]      v4, r4o;
  logic [3:0][7:0] d4;
  logic            rdy4, vo4;
  logic [7:0]      do4;
  logic [1:0]      io4;

  logic [2:0]      v3, r3o;
  logic [2:0][7:0] d3;
  logic            rdy3, vo3;
  logic [7:0]      do3;
  logic [1:0]      io3;

`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
  logic [3:0][1:0] gc4;
  logic [2:0][1:0] gc3;
`endif

  stream_rr_arb_reg #(
    .NumInp(4), .T(logic [7:0]), .CntWidth(2)
  ) u4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .valid_i(v4), .ready_o(r4o), .data_i(d4),
    .valid_o(vo4), .ready_i(rdy4), .data_o(do4),
    .idx_o(io4)
`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
    , .grant_cnt_o(gc4)
`endif
  );

  stream_rr_arb_reg #(
    .NumInp(3), .T(logic [7:0]), .CntWidth(2)
  ) u3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .valid_i(v3), .ready_o(r3o), .data_i(d3),
    .valid_o(vo3), .ready_i(rdy3), .data_o(do3),
    .idx_o(io3)
`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
    , .grant_cnt_o(gc3)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: slot 0 = 4-input DUT, slot 1 = 3-input DUT
  int         mv[2];
  int         mi[2];
  int         mp[2];
  logic [7:0] md[2];
  int         mc[2][4];

  function automatic int win_of(int p, logic [3:0] v, int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = (p + i) % n;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int j, logic [3:0] v,
                                         logic r, int n);
    int w;
    if (rst || clr) return 4'b0;
    w = win_of(mp[j], v, n);
    if ((r || mv[j] == 0) && w >= 0) return 4'(1 << w);
    return 4'b0;
  endfunction

  task automatic upd(input int j, input int n, input logic [3:0] v,
                     input logic r, input logic [3:0][7:0] d);
    int w;
    if (rst || clr) begin
      mv[j] = 0; mi[j] = 0; mp[j] = 0; md[j] = 8'h00;
      for (int k = 0; k < 4; k++) mc[j][k] = 0;
    end else if (r || mv[j] == 0) begin
      w = win_of(mp[j], v, n);
      if (w >= 0) begin
        mv[j] = 1; mi[j] = w; md[j] = d[w];
        mp[j] = (w + 1) % n;
        if (mc[j][w] < 3) mc[j][w] = mc[j][w] + 1;
      end else begin
        mv[j] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    upd(0, 4, v4, rdy4, d4);
    upd(1, 3, {1'b0, v3}, rdy3, {8'h00, d3});
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    v4 = 4'hF; v3 = 3'h7; rdy4 = 1'b1; rdy3 = 1'b1;
    d4 = 32'h44332211; d3 = 24'h332211;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if (vo4 !== 1'b0 || io4 !== 2'd0 || r4o !== 4'b0) begin
        n_fail++;
        $display("FAIL reset4 valid=%b idx=%0d rdy=%b want 0/0/0",
                 vo4, io4, r4o);
      end
      n_chk++;
      if (vo3 !== 1'b0 || r3o !== 3'b0) begin
        n_fail++;
        $display("FAIL reset3 valid=%b rdy=%b want 0/0", vo3, r3o);
      end
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (r4o !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant rdy=%b want 0001", r4o);
    end
    tick();
    n_chk++;
    if (vo4 !== 1'b1 || io4 !== 2'd0 || do4 !== 8'h11) begin
      n_fail++;
      $display("FAIL first_beat v=%b idx=%0d data=%h want 1/0/11",
               vo4, io4, do4);
    end
    v3 = 3'b0;
  endtask

  task automatic test_full_load();
    do_clear();
    v4 = 4'hF; rdy4 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      d4 = {$urandom, 8'h0} | 32'($urandom_range(0, 255));
      #1;
      n_chk++;
      if (r4o !== 4'(1 << (c % 4))) begin
        n_fail++;
        $display("FAIL load_rdy c=%0d got %b want %b",
                 c, r4o, 4'(1 << (c % 4)));
      end
      tick();
      n_chk++;
      if (vo4 !== 1'b1 || io4 !== 2'(c % 4) || do4 !== md[0]) begin
        n_fail++;
        $display("FAIL load_beat c=%0d v=%b idx=%0d d=%h want 1/%0d/%h",
                 c, vo4, io4, do4, c % 4, md[0]);
      end
    end
  endtask

  task automatic test_stall();
    do_clear();
    v4 = 4'b0100; d4 = 32'h00A50000; rdy4 = 1'b0;
    tick();
    v4 = 4'hF;
    for (int c = 0; c < 3; c++) begin
      d4 = $urandom;
      #1;
      n_chk++;
      if (r4o !== 4'b0) begin
        n_fail++;
        $display("FAIL stall_rdy c=%0d got %b want 0000", c, r4o);
      end
      tick();
      n_chk++;
      if (vo4 !== 1'b1 || do4 !== 8'hA5 || io4 !== 2'd2) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d v=%b d=%h idx=%0d want 1/a5/2",
                 c, vo4, do4, io4);
      end
    end
    rdy4 = 1'b1;
    #1;
    n_chk++;
    if (r4o !== 4'b1000) begin
      n_fail++;
      $display("FAIL stall_next_rdy got %b want 1000", r4o);
    end
    tick();
    n_chk++;
    if (io4 !== 2'd3 || vo4 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_next idx=%0d v=%b want 3/1", io4, vo4);
    end
    v4 = 4'b0;
  endtask

  task automatic test_sparse_wrap();
    int seq[4] = '{2, 0, 2, 0};
    do_clear();
    v3 = 3'b001; rdy3 = 1'b1; d3 = 24'h030201;
    tick();
    v3 = 3'b101;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_chk++;
      if (vo3 !== 1'b1 || io3 !== 2'(seq[c])) begin
        n_fail++;
        $display("FAIL sparse c=%0d v=%b idx=%0d want 1/%0d",
                 c, vo3, io3, seq[c]);
      end
    end
    v3 = 3'b000;
    tick();
    n_chk++;
    if (vo3 !== 1'b0 || io3 !== 2'd0 || do3 !== 8'h01) begin
      n_fail++;
      $display("FAIL drain v=%b idx=%0d d=%h want 0/0/01",
               vo3, io3, do3);
    end
  endtask

  task automatic test_clear();
    do_clear();
    v4 = 4'b0001; rdy4 = 1'b0; d4 = 32'h0;
    tick();
    clr = 1'b1; v4 = 4'b0010; rdy4 = 1'b1;
    #1;
    n_chk++;
    if (r4o !== 4'b0) begin
      n_fail++;
      $display("FAIL clr_rdy got %b want 0000", r4o);
    end
    tick();
    clr = 1'b0;
    n_chk++;
    if (vo4 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_valid got %b want 0", vo4);
    end
    v4 = 4'hF;
    #1;
    n_chk++;
    if (r4o !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_ptr rdy=%b want 0001", r4o);
    end
    tick();
    v4 = 4'b0;
  endtask

`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
  task automatic test_counters();
    do_clear();
    v4 = 4'b0010; rdy4 = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    n_chk++;
    if (gc4 !== {2'd0, 2'd0, 2'd3, 2'd0}) begin
      n_fail++;
      $display("FAIL cnt_sat got %h want %h", gc4, 8'b00001100);
    end
    v4 = 4'b0;
    do_clear();
    n_chk++;
    if (gc4 !== 8'h0) begin
      n_fail++;
      $display("FAIL cnt_clr got %h want 00", gc4);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] er4, er3;
    for (int c = 0; c < 400; c++) begin
      v4 = 4'($urandom); v3 = 3'($urandom);
      d4 = $urandom; d3 = 24'($urandom);
      rdy4 = ($urandom_range(0, 3) != 0);
      rdy3 = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 40) == 0);
      #1;
      er4 = exp_rdy(0, v4, rdy4, 4);
      er3 = exp_rdy(1, {1'b0, v3}, rdy3, 3);
      n_chk++;
      if (r4o !== er4 || {1'b0, r3o} !== er3) begin
        n_fail++;
        $display("FAIL rnd_rdy c=%0d got %b/%b want %b/%b",
                 c, r4o, r3o, er4, er3[2:0]);
      end
      tick();
      n_chk++;
      if (vo4 !== 1'(mv[0]) || io4 !== 2'(mi[0]) || do4 !== md[0]) begin
        n_fail++;
        $display("FAIL rnd_out4 c=%0d got %b/%0d/%h want %0d/%0d/%h",
                 c, vo4, io4, do4, mv[0], mi[0], md[0]);
      end
      n_chk++;
      if (vo3 !== 1'(mv[1]) || io3 !== 2'(mi[1]) || do3 !== md[1]) begin
        n_fail++;
        $display("FAIL rnd_out3 c=%0d got %b/%0d/%h want %0d/%0d/%h",
                 c, vo3, io3, do3, mv[1], mi[1], md[1]);
      end
`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (gc4[k] !== 2'(mc[0][k])) begin
          n_fail++;
          $display("FAIL rnd_cnt4 k=%0d got %0d want %0d",
                   k, gc4[k], mc[0][k]);
        end
      end
`endif
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_sparse_wrap();
    test_clear();
`ifdef STREAM_RR_ARB_REG_GRANT_CNT_EN
    test_counters();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
